dot_operand_loader: RTL and testbench

DOT_OPERAND_LOADER -- requirements
Module: dot_operand_loader

---
 rtl/dot_operand_loader_pkg.sv | 18 +
 rtl/dot_operand_loader_bank.sv | 78 +++++++
 rtl/dot_operand_loader.sv | 72 +++++++
 tb/tb_dot_operand_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_operand_loader_pkg.sv
// Shared widths, lane count and bank-state encoding for the dot-product operand loader.
package dot_operand_loader_pkg;

  localparam int WGT_W   = 19;
  localparam int PIX_W   = 10;
  localparam int N_LANES = 10;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_LANES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_LANES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } bank_state_t;

endpackage

// File: rtl/dot_operand_loader_bank.sv
// One operand bank: ten weight and ten pixel lanes, per-class fill counts and the
// EMPTY/FILL/FULL state. The bank becomes FULL one edge after its last lane is written.
module operand_bank
  import dot_operand_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_is_wgt,
  input  logic [WGT_W-1:0]           wr_data,
  input  logic                       clr,
  output logic [N_LANES*WGT_W-1:0]   wgt_flat,
  output logic [N_LANES*PIX_W-1:0]   pix_flat,
  output bank_state_t                state,
  output logic                       wr_drop,
  output logic                       wr_done
);

  logic [WGT_W-1:0] wgt_q [N_LANES];
  logic [PIX_W-1:0] pix_q [N_LANES];
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] cls_cnt;
  logic             wr_ok;
  bank_state_t      state_q;
  bank_state_t      state_d;

  assign cls_cnt = wr_is_wgt ? wcnt_q : pcnt_q;
  assign wr_drop = wr_en && (cls_cnt == CNT_MAX);
  assign wr_ok   = wr_en && !wr_drop;
  // Completion: this write fills the last free lane while the other class is already full.
  assign wr_done = wr_ok && (wr_is_wgt ? (wcnt_q == CNT_LAST && pcnt_q == CNT_MAX)
                                       : (pcnt_q == CNT_LAST && wcnt_q == CNT_MAX));
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = EMPTY;
    else if (wr_ok)
      state_d = FILL;
    else if (state_q == FILL && wcnt_q == CNT_MAX && pcnt_q == CNT_MAX)
      state_d = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        wgt_q[k] <= '0;
        pix_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (clr) begin
        wcnt_q <= '0;
        pcnt_q <= '0;
      end else if (wr_ok) begin
        if (wr_is_wgt) wcnt_q <= wcnt_q + 1'b1;
        else           pcnt_q <= pcnt_q + 1'b1;
        for (int k = 0; k < N_LANES; k++) begin
          if (cls_cnt == CNT_W'(k)) begin
            if (wr_is_wgt) wgt_q[k] <= wr_data;
            else           pix_q[k] <= wr_data[PIX_W-1:0];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_flat
    assign wgt_flat[k*WGT_W +: WGT_W] = wgt_q[k];
    assign pix_flat[k*PIX_W +: PIX_W] = pix_q[k];
  end

endmodule

// File: rtl/dot_operand_loader.sv
// Double-buffered operand loader: one bank fills from the word stream while the other
// is presented to the dot-product engine; pointers and handshakes live here.
module dot_operand_loader
  import dot_operand_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_wgt,
  input  logic [WGT_W-1:0]          in_data,
  output logic [N_LANES*WGT_W-1:0]  wgt_bus,
  output logic [N_LANES*PIX_W-1:0]  pix_bus,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic                      err_drop
);

  logic                     fill_ptr;
  logic                     pres_ptr;
  logic                     xfer;
  logic                     consume;
  logic [1:0]               wr_en_b;
  logic [1:0]               clr_b;
  logic [1:0]               drop_b;
  logic [1:0]               done_b;
  bank_state_t              state_b [2];
  logic [N_LANES*WGT_W-1:0] wgt_b   [2];
  logic [N_LANES*PIX_W-1:0] pix_b   [2];

  // Ready is forced low while reset is held; banks are EMPTY then, so release yields ready at once.
  assign in_ready = GlobalReset && (state_b[fill_ptr] != FULL);
  assign op_valid = (state_b[pres_ptr] == FULL);
  assign xfer     = in_valid && in_ready;
  assign consume  = op_valid && op_ready;

  assign wr_en_b  = {xfer && fill_ptr, xfer && !fill_ptr};
  assign clr_b    = {consume && pres_ptr, consume && !pres_ptr};

  assign wgt_bus  = pres_ptr ? wgt_b[1] : wgt_b[0];
  assign pix_bus  = pres_ptr ? pix_b[1] : pix_b[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_bank u_bank (
      .clk       (clk),
      .rst_n     (GlobalReset),
      .wr_en     (wr_en_b[b]),
      .wr_is_wgt (in_is_wgt),
      .wr_data   (in_data),
      .clr       (clr_b[b]),
      .wgt_flat  (wgt_b[b]),
      .pix_flat  (pix_b[b]),
      .state     (state_b[b]),
      .wr_drop   (drop_b[b]),
      .wr_done   (done_b[b])
    );
  end

  // fill_ptr moves on the completing edge so a streaming word never hits the finished bank.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      fill_ptr <= 1'b0;
      pres_ptr <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      fill_ptr <= fill_ptr ^ (|done_b);
      pres_ptr <= pres_ptr ^ consume;
      err_drop <= |drop_b;
    end
  end

endmodule

// File: tb/tb_dot_operand_loader.sv
// Scoreboard bench for dot_operand_loader: completed sets are queued by the stimulus
// and checked against the buses by a monitor at every handoff.
module tb_dot_operand_loader;

  logic         clk;
  logic         GlobalReset;
  logic         in_valid;
  logic         in_ready;
  logic         in_is_wgt;
  logic [18:0]  in_data;
  logic [189:0] wgt_bus;
  logic [99:0]  pix_bus;
  logic         op_valid;
  logic         op_ready;
  logic         err_drop;

  typedef struct packed {
    logic [189:0] w;
    logic [99:0]  p;
  } set_t;

  set_t sb_q [$];
  int   n_tests;
  int   n_fail;
  int   drop_cnt;
  int   stall_cnt;
  int   cyc;

  dot_operand_loader dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_is_wgt   (in_is_wgt),
    .in_data     (in_data),
    .wgt_bus     (wgt_bus),
    .pix_bus     (pix_bus),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .err_drop    (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the presented set at each handoff and tallies drop pulses and stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (GlobalReset) begin
        if (err_drop) drop_cnt++;
        if (in_valid && !in_ready) stall_cnt++;
        if (op_valid && op_ready) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL handoff_unexpected: got set with pix %0h expected no set", pix_bus);
          end else begin
            set_t e;
            e = sb_q.pop_front();
            if (wgt_bus !== e.w) begin
              n_fail++;
              $display("FAIL wgt_bus: got %0h expected %0h", wgt_bus, e.w);
            end
            n_tests++;
            if (pix_bus !== e.p) begin
              n_fail++;
              $display("FAIL pix_bus: got %0h expected %0h", pix_bus, e.p);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic is_wgt, input logic [18:0] d);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_is_wgt = is_wgt;
    in_data   = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_word_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // mode 0: pixels then weights; 1: interleaved plus an 11th pixel 0x3FF; 2: weights then pixels.
  task automatic send_set(input int pbase, input int wbase, input int mode, input bit keep);
    set_t e;
    for (int k = 0; k < 10; k++) begin
      e.w[k*19 +: 19] = 19'(wbase + k);
      e.p[k*10 +: 10] = 10'(pbase + k);
    end
    if (mode == 0) begin
      for (int k = 0; k < 10; k++) send_word(1'b0, 19'(pbase + k));
      for (int k = 0; k < 10; k++) send_word(1'b1, 19'(wbase + k));
    end else if (mode == 1) begin
      for (int k = 0; k < 9; k++) begin
        send_word(1'b0, 19'(pbase + k));
        send_word(1'b1, 19'(wbase + k));
      end
      send_word(1'b0, 19'(pbase + 9));
      send_word(1'b0, 19'h003FF);
      send_word(1'b1, 19'(wbase + 9));
    end else begin
      for (int k = 0; k < 10; k++) send_word(1'b1, 19'(wbase + k));
      for (int k = 0; k < 10; k++) send_word(1'b0, 19'(pbase + k));
    end
    sb_q.push_back(e);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic consume();
    int t;
    t = 0;
    while (!op_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!op_valid) chk("consume_op_valid_timeout", 32'(op_valid), 32'd1);
    else begin
      op_ready = 1'b1;
      @(posedge clk);
      #1;
      op_ready = 1'b0;
    end
  endtask

  initial begin
    int c0;
    int s0;
    n_tests = 0; n_fail = 0; drop_cnt = 0; stall_cnt = 0; cyc = 0;
    GlobalReset = 1'b0;
    in_valid = 1'b0; in_is_wgt = 1'b0; in_data = '0; op_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_buses_zero", 32'((wgt_bus == '0) && (pix_bus == '0)), 32'd1);
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Pixels 1..10 then weights 0x100..0x109, latency of one cycle to op_valid
    send_set(1, 'h100, 0, 1'b0);
    chk("latency_not_yet", 32'(op_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_op_valid", 32'(op_valid), 32'd1);
    chk("other_bank_ready", 32'(in_ready), 32'd1);
    chk("pix_lane0", 32'(pix_bus[9:0]), 32'd1);
    chk("wgt_lane9", 32'(wgt_bus[189:171]), 32'h109);
    consume();
    chk("after_consume_op_valid", 32'(op_valid), 32'd0);

    // Interleaved with an overflowing pixel
    send_set('h20, 'h200, 1, 1'b0);
    chk("drop_pulses", drop_cnt, 32'd1);
    consume();

    // Two sets queued with op_ready low
    send_set('h40, 'h300, 0, 1'b0);
    send_set('h60, 'h380, 2, 1'b0);
    chk("both_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("both_full_in_ready_hold", 32'(in_ready), 32'd0);
    chk("both_full_op_valid", 32'(op_valid), 32'd1);
    chk("set1_pix_lane3", 32'(pix_bus[39:30]), 32'h43);
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    chk("after_release_in_ready", 32'(in_ready), 32'd1);
    chk("set2_presented", 32'(op_valid), 32'd1);
    consume();

    // Continuous stream with op_ready held high
    op_ready = 1'b1;
    c0 = cyc;
    s0 = stall_cnt;
    send_set('h80, 'h400, 0, 1'b1);
    send_set('hA0, 'h500, 1 * 2, 1'b1);
    send_set('hC0, 'h600, 0, 1'b0);
    chk("stream_cycles", cyc - c0, 32'd60);
    chk("stream_stalls", stall_cnt - s0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("stream_drained", sb_q.size(), 32'd0);
    op_ready = 1'b0;

    // Asynchronous reset mid-fill
    for (int k = 0; k < 7; k++) send_word(1'b0, 19'('h11 + k));
    in_valid = 1'b0;
    chk("partial_visible", 32'(pix_bus[9:0]), 32'h11);
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_op_valid", 32'(op_valid), 32'd0);
    chk("async_rst_buses", 32'((wgt_bus == '0) && (pix_bus == '0) && !err_drop), 32'd1);
    @(posedge clk);
    #3;
    GlobalReset = 1'b1;
    @(posedge clk);
    #1;

    // op_ready with nothing presented must not move pres_ptr
    op_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_ready_op_valid", 32'(op_valid), 32'd0);
    op_ready = 1'b0;
    send_set('h70, 'h10, 0, 1'b0);
    @(posedge clk);
    #1;
    chk("set_in_bank0", 32'(op_valid), 32'd1);
    consume();

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("total_drops", drop_cnt, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
